lcd_refresh_scheduler: RTL and testbench
========================================

// Module: lcd_refresh_scheduler
// PURPOSE
//  Sequences the 128x64 serial LCD: power-up delay, controller init list, then full-frame
//  refreshes from the frame-buffer RAM, page by page (3 page/column commands + 128 data bytes).
//  Sits between the frame-buffer RAM read port and the 4-wire LCD pins.
//  Serialisation is done by the sub-module lcd_spi_byte_tx.
// PARAMETERS
//  CLK_DIV     4     clk cycles per SCL half-period (>=1)
//  INIT_DELAY  1000  clk cycles held idle after reset release before the first init byte
//  COLS        128   data bytes per page
//  PAGES       8     pages per frame
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  frame_req     in   1   1-cycle pulse: request one full refresh
//  auto_refresh  in   1   1 = start a new frame as soon as the previous one ends
//  ram_addr      out  10  frame-buffer read address = page*COLS + col
//  ram_q         in   8   RAM data, valid 2 clk after ram_addr changes (registered RAM)
//  lcd           out  4   {SI, A0, SCL, CS} = lcd[3:0] bit order {3,2,1,0}
//  init_done     out  1   high once the init list has been sent
//  frame_busy    out  1   high from the first page command to the last data byte done
//  frame_done    out  1   1-cycle pulse when the last byte of a frame finishes
// BEHAVIOUR
//  Reset values: lcd = {SI=0,A0=0,SCL=1,CS=1}; ram_addr=0; init_done=0; frame_busy=0;
//   frame_done=0; pending=0; FSM=WAIT.
//   Reset asserted mid-byte aborts immediately: CS goes high asynchronously, no partial-byte resume.
//  Byte transfer (lcd_spi_byte_tx, start/busy handshake):
//   - start is accepted only when busy=0; A0 and the byte are latched on start.
//   - CS falls; after CLK_DIV cycles the 8 bits are sent MSB first.
//   - Each bit: SCL low for CLK_DIV cycles with SI set at the falling edge, then SCL high
//     for CLK_DIV cycles. The LCD samples on the SCL rise.
//   - After the 8th bit, CS goes high for CLK_DIV cycles.
//   - busy stays high for exactly 18*CLK_DIV cycles from the cycle after start.
//  A0: 0 for command bytes, 1 for data bytes.
//  FSM states:
//   WAIT: count INIT_DELAY cycles -> INIT.
//   INIT: send the 12 package init bytes in order -> set init_done -> IDLE.
//   IDLE: go to PCMD if pending, or if frame_req arrives in this cycle, or if auto_refresh=1.
//         Clear pending when leaving. Set frame_busy, page=0.
//   PCMD: send B0|page, 10, 00 (A0=0) -> col=0, FETCH.
//   FETCH: drive ram_addr, wait 2 cycles -> DATA.
//   DATA: send ram_q (A0=1). When busy drops: col++.
//         If col==COLS: page++; if page==PAGES -> DONE, else -> PCMD. Otherwise -> FETCH.
//   DONE: pulse frame_done, clear frame_busy -> IDLE.
//  frame_req received in WAIT, INIT or during a frame sets pending.
//   Multiple requests coalesce into one frame. A request arriving in the same cycle as
//   frame_done is kept as pending.
//  Each frame is exactly PAGES*(3+COLS) = 1048 bytes.
//   The next-byte start is issued in the cycle after busy falls (DATA adds the 2-cycle fetch).
//  Address arithmetic: page is 3 bits and col is 7 bits, so ram_addr = {page,col} with no wrap.
//  Counters saturate at their terminal value and never wrap mid-frame.
//  Changing auto_refresh mid-frame takes effect only in IDLE.
// STRUCTURE
//  Package lcd_pkg: INIT_LIST[0:11] = E2,AF,40,A0,A7,A4,A2,C8,2F,24,81,24; CMD_PAGE=B0;
//   CMD_COLH=10; CMD_COLL=00; state encoding localparams.
//  Sub-module lcd_spi_byte_tx (CLK_DIV): ports clk, rst_n, start, a0, byte, busy, lcd[3:0].
// TESTING
//  1. Reset, CLK_DIV=1, INIT_DELAY=10 -> CS stays high 10 cycles; then 12 bytes E2..24
//     with A0=0; init_done rises after the 12th byte.
//  2. RAM holds addr[7:0]; one frame_req -> 1048 bytes. Page p starts B0+p,10,00;
//     data byte k of page 1 = 0x80+k; one frame_done; frame_busy low after it.
//  3. Three frame_req pulses during a frame -> exactly one further frame, then IDLE.
//  4. frame_req in the same cycle as frame_done -> second frame starts, no gap beyond one IDLE cycle.
//  5. rst_n low in the middle of data byte 40 of page 3 -> CS=1 and outputs at reset values
//     in the same cycle; after release, WAIT and the full init list repeat.
//  6. Bit timing, CLK_DIV=4 -> each SCL half-period is 4 cycles; SI stable across the rise;
//     busy width is 72 cycles.

Source files
------------

// File: rtl/lcd_refresh_scheduler_pkg.sv
// Shared constants for the 128x64 serial LCD scheduler: controller init list,
// page/column command opcodes and the sequencer state encoding.
package lcd_pkg;

  localparam int         RAM_AW   = 10;
  localparam int         INIT_LEN = 12;
  localparam logic [7:0] CMD_PAGE = 8'hB0;
  localparam logic [7:0] CMD_COLH = 8'h10;
  localparam logic [7:0] CMD_COLL = 8'h00;

  // Bias, ADC/COM direction, booster/regulator/follower on, contrast.
  localparam logic [7:0] INIT_LIST [0:INIT_LEN-1] = '{
    8'hE2, 8'hAF, 8'h40, 8'hA0, 8'hA7, 8'hA4,
    8'hA2, 8'hC8, 8'h2F, 8'h24, 8'h81, 8'h24
  };

  typedef enum logic [2:0] {
    ST_WAIT, ST_INIT, ST_IDLE, ST_PCMD, ST_FETCH, ST_DATA, ST_DONE
  } state_t;

  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    return (int'(idx) < INIT_LEN) ? INIT_LIST[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/lcd_refresh_scheduler_if.sv
// Frame-buffer read port, LCD pins and frame control/status of the scheduler.
interface lcd_refresh_scheduler_if;
  import lcd_pkg::*;

  logic              frame_req;
  logic              auto_refresh;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_q;
  logic [3:0]        lcd;
  logic              init_done;
  logic              frame_busy;
  logic              frame_done;

  modport master (
    input  frame_req, auto_refresh, ram_q,
    output ram_addr, lcd, init_done, frame_busy, frame_done
  );

  modport slave (
    output frame_req, auto_refresh, ram_q,
    input  ram_addr, lcd, init_done, frame_busy, frame_done
  );
endinterface

// File: rtl/lcd_refresh_scheduler_spi.sv
// One-byte 4-wire LCD serialiser: CS setup phase, 8 MSB-first bits, CS-high gap.
// Each of the 18 phases lasts CLK_DIV cycles, so busy is 18*CLK_DIV wide.
module lcd_spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_a0,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic [3:0] o_lcd
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             r_busy;
  logic             r_a0;
  logic [7:0]       r_sh;
  logic [4:0]       r_ph;
  logic [DIV_W-1:0] r_div;
  logic             w_div_end;
  logic             w_cs, w_scl, w_si, w_a0;

  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_a0   <= 1'b0;
      r_sh   <= '0;
      r_ph   <= '0;
      r_div  <= '0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy <= 1'b1;
        r_a0   <= i_a0;
        r_sh   <= i_byte;
        r_ph   <= '0;
        r_div  <= '0;
      end
    end else if (w_div_end) begin
      r_div <= '0;
      if (r_ph == 5'd17) r_busy <= 1'b0;
      else               r_ph   <= r_ph + 5'd1;
      // Advance the bit as SCL falls, i.e. leaving each high phase 2..16.
      if (!r_ph[0] && r_ph != 5'd0) r_sh <= {r_sh[6:0], 1'b0};
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Pins decode straight from reset-cleared state, so reset forces CS high at once.
  assign w_cs   = !r_busy || (r_ph == 5'd17);
  assign w_scl  = !(r_busy && r_ph[0] && (r_ph != 5'd17));
  assign w_si   = (r_busy && r_ph != 5'd0 && r_ph != 5'd17) ? r_sh[7] : 1'b0;
  assign w_a0   = r_busy ? r_a0 : 1'b0;
  assign o_lcd  = {w_si, w_a0, w_scl, w_cs};
  assign o_busy = r_busy;

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// LCD refresh sequencer: power-up wait, init list, then page-by-page frame pushes
// from the frame-buffer RAM through the byte serialiser.
module lcd_refresh_scheduler
  import lcd_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int INIT_DELAY = 1000,
  parameter int COLS       = 128,
  parameter int PAGES      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lcd_refresh_scheduler_if.master bus
);
  localparam int COL_W  = (COLS > 1)       ? $clog2(COLS)       : 1;
  localparam int PAGE_W = (PAGES > 1)      ? $clog2(PAGES)      : 1;
  localparam int DLY_W  = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;

  state_t              r_state, w_state;
  logic [DLY_W-1:0]    r_dly, w_dly;
  logic [3:0]          r_idx, w_idx;
  logic [PAGE_W-1:0]   r_page, w_page;
  logic [COL_W-1:0]    r_col, w_col;
  logic                r_pending, w_pending;
  logic                r_init_done, w_init_done;
  logic                r_frame_busy, w_frame_busy;
  logic                r_frame_done, w_frame_done;
  logic                w_start, w_a0, w_busy;
  logic [7:0]          w_byte;
  logic [3:0]          w_lcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_WAIT;
      r_dly        <= '0;
      r_idx        <= '0;
      r_page       <= '0;
      r_col        <= '0;
      r_pending    <= 1'b0;
      r_init_done  <= 1'b0;
      r_frame_busy <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_dly        <= w_dly;
      r_idx        <= w_idx;
      r_page       <= w_page;
      r_col        <= w_col;
      r_pending    <= w_pending;
      r_init_done  <= w_init_done;
      r_frame_busy <= w_frame_busy;
      r_frame_done <= w_frame_done;
    end
  end

  // r_idx is the next byte to launch in INIT/PCMD, the fetch wait in FETCH,
  // and the launched flag in DATA; a byte is finished when busy is low again.
  always_comb begin
    w_state      = r_state;
    w_dly        = r_dly;
    w_idx        = r_idx;
    w_page       = r_page;
    w_col        = r_col;
    w_pending    = r_pending | bus.frame_req;
    w_init_done  = r_init_done;
    w_frame_busy = r_frame_busy;
    w_frame_done = 1'b0;
    w_start      = 1'b0;
    w_a0         = 1'b0;
    w_byte       = '0;
    unique case (r_state)
      ST_WAIT:
        if (r_dly == DLY_W'(INIT_DELAY - 1)) w_state = ST_INIT;
        else                                 w_dly   = r_dly + 1'b1;
      ST_INIT:
        if (!w_busy) begin
          if (r_idx == 4'(INIT_LEN)) begin
            w_init_done = 1'b1;
            w_idx       = '0;
            w_state     = ST_IDLE;
          end else begin
            w_start = 1'b1;
            w_byte  = init_byte(r_idx);
            w_idx   = r_idx + 4'd1;
          end
        end
      ST_IDLE:
        if (r_pending || bus.frame_req || bus.auto_refresh) begin
          w_pending    = 1'b0;
          w_frame_busy = 1'b1;
          w_page       = '0;
          w_idx        = '0;
          w_state      = ST_PCMD;
        end
      ST_PCMD:
        if (!w_busy) begin
          if (r_idx == 4'd3) begin
            w_col   = '0;
            w_idx   = '0;
            w_state = ST_FETCH;
          end else begin
            w_start = 1'b1;
            w_byte  = (r_idx == 4'd0) ? (CMD_PAGE | 8'(r_page)) :
                      (r_idx == 4'd1) ? CMD_COLH : CMD_COLL;
            w_idx   = r_idx + 4'd1;
          end
        end
      ST_FETCH:
        if (r_idx == 4'd1) begin
          w_idx   = '0;
          w_state = ST_DATA;
        end else begin
          w_idx = r_idx + 4'd1;
        end
      ST_DATA:
        if (!w_busy) begin
          if (r_idx == 4'd0) begin
            w_start = 1'b1;
            w_a0    = 1'b1;
            w_byte  = bus.ram_q;
            w_idx   = 4'd1;
          end else begin
            w_idx = '0;
            if (r_col == COL_W'(COLS - 1)) begin
              if (r_page == PAGE_W'(PAGES - 1)) begin
                w_frame_done = 1'b1;
                w_frame_busy = 1'b0;
                w_state      = ST_DONE;
              end else begin
                w_page  = r_page + 1'b1;
                w_state = ST_PCMD;
              end
            end else begin
              w_col   = r_col + 1'b1;
              w_state = ST_FETCH;
            end
          end
        end
      ST_DONE:
        w_state = ST_IDLE;
      default:
        w_state = ST_WAIT;
    endcase
  end

  lcd_spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_a0    (w_a0),
    .i_byte  (w_byte),
    .o_busy  (w_busy),
    .o_lcd   (w_lcd)
  );

  assign bus.ram_addr   = RAM_AW'(r_page) * RAM_AW'(COLS) + RAM_AW'(r_col);
  assign bus.lcd        = w_lcd;
  assign bus.init_done  = r_init_done;
  assign bus.frame_busy = r_frame_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Directed bench: full-size instance (CLK_DIV=1) for init/frame/reset, and a
// small instance (CLK_DIV=4, 4x2 frame) for bit timing, request coalescing and auto refresh.
module tb_lcd_refresh_scheduler;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  lcd_refresh_scheduler_if ifa();
  lcd_refresh_scheduler_if ifb();

  lcd_refresh_scheduler #(.CLK_DIV(1), .INIT_DELAY(10), .COLS(128), .PAGES(8)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ifa));
  lcd_refresh_scheduler #(.CLK_DIV(4), .INIT_DELAY(5), .COLS(4), .PAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ifb));

  // Registered RAMs holding addr[7:0]: data two clocks after the address.
  logic [9:0] ra1, rb1;
  always @(posedge clk) begin
    ra1 <= ifa.ram_addr;  ifa.ram_q <= ra1[7:0];
    rb1 <= ifb.ram_addr;  ifb.ram_q <= rb1[7:0];
  end

  logic [7:0] init_exp [12] = '{8'hE2, 8'hAF, 8'h40, 8'hA0, 8'hA7, 8'hA4,
                                8'hA2, 8'hC8, 8'h2F, 8'h24, 8'h81, 8'h24};

  // LCD-side receiver: shift SI on each SCL rise while CS is low, push {A0,byte}.
  logic [8:0] qa[$], qb[$];
  logic [3:0] lcd_s [2];
  logic       prv_scl [2] = '{1'b1, 1'b1};
  logic       prv_si  [2] = '{1'b0, 1'b0};
  logic [7:0] sh      [2] = '{8'h00, 8'h00};
  int         nbit    [2] = '{0, 0};
  int         ndone   [2] = '{0, 0};
  int         si_bad = 0;

  always_comb begin
    lcd_s[0] = ifa.lcd;
    lcd_s[1] = ifb.lcd;
  end

  always @(negedge clk) begin
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      if (lcd_s[i][0]) nbit[i] = 0;
      else if (!prv_scl[i] && lcd_s[i][1]) begin
        if (lcd_s[i][3] != prv_si[i]) si_bad++;
        b = {sh[i][6:0], lcd_s[i][3]};
        sh[i] = b;
        nbit[i]++;
        if (nbit[i] == 8) begin
          if (i == 0) qa.push_back({lcd_s[i][2], b});
          else        qb.push_back({lcd_s[i][2], b});
          nbit[i] = 0;
        end
      end
      prv_scl[i] = lcd_s[i][1];
      prv_si[i]  = lcd_s[i][3];
    end
    if (ifa.frame_done) ndone[0]++;
    if (ifb.frame_done) ndone[1]++;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic pulse_req_b();
    ifb.frame_req = 1'b1;
    @(negedge clk);
    ifb.frame_req = 1'b0;
  endtask

  // Called at the negedge where instance A leaves reset.
  task automatic run_init_a(input string pfx);
    int n, hi, base;
    base = qa.size();
    n = 0; hi = 0;
    while (ifa.lcd[0] && n < 100) begin
      @(negedge clk); n++;
      if (n <= 10 && ifa.lcd[0]) hi++;
    end
    chk({pfx, "_cs_hi"}, hi, 10);
    chk({pfx, "_first_cs_low"}, n, 11);
    n = 0;
    while (qa.size() < base + 12 && n < 2000) begin @(negedge clk); n++; end
    chk({pfx, "_done_early"}, ifa.init_done, 0);
    for (int i = 0; i < 12; i++) chk({pfx, "_byte"}, qa[base+i], {1'b0, init_exp[i]});
    n = 0;
    while (!ifa.init_done && n < 200) begin @(negedge clk); n++; end
    chk({pfx, "_init_done"}, ifa.init_done, 1);
  endtask

  initial begin
    int n, base, d0, errs, runs, bad, len, gap;
    logic prv;
    ifa.frame_req = 1'b0; ifa.auto_refresh = 1'b0;
    ifb.frame_req = 1'b0; ifb.auto_refresh = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_lcd",   ifa.lcd, 4'b0011);
    chk("rst_addr",  ifa.ram_addr, 0);
    chk("rst_init",  ifa.init_done, 0);
    chk("rst_fbusy", ifa.frame_busy, 0);
    chk("rst_fdone", ifa.frame_done, 0);

    rst_a = 1'b1;
    run_init_a("init");

    // One full frame from an idle scheduler.
    base = qa.size(); d0 = ndone[0];
    ifa.frame_req = 1'b1; @(negedge clk); ifa.frame_req = 1'b0;
    chk("fbusy_on", ifa.frame_busy, 1);
    n = 0;
    while (ndone[0] == d0 && n < 40000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("frame_nbytes", qa.size() - base, 1048);
    chk("frame_ndone", ndone[0] - d0, 1);
    chk("fbusy_off", ifa.frame_busy, 0);
    chk("p1_d0",   qa[base+131+3],   {1'b1, 8'h80});
    chk("p1_d5",   qa[base+131+8],   {1'b1, 8'h85});
    chk("p3_cmd0", qa[base+3*131],   {1'b0, 8'hB3});
    chk("p7_last", qa[base+7*131+130], {1'b1, 8'hFF});
    errs = 0;
    if (qa.size() >= base + 1048)
      for (int p = 0; p < 8; p++) begin
        if (qa[base+p*131]   !== {1'b0, 8'hB0 + 8'(p)}) errs++;
        if (qa[base+p*131+1] !== {1'b0, 8'h10}) errs++;
        if (qa[base+p*131+2] !== {1'b0, 8'h00}) errs++;
        for (int k = 0; k < 128; k++)
          if (qa[base+p*131+3+k] !== {1'b1, 8'(p*128+k)}) errs++;
      end
    else errs = 1;
    chk("frame_errs", errs, 0);

    // Reset in the middle of data byte 40 of page 3.
    base = qa.size();
    ifa.frame_req = 1'b1; @(negedge clk); ifa.frame_req = 1'b0;
    n = 0;
    while (qa.size() < base + 3*131 + 3 + 40 && n < 20000) begin @(negedge clk); n++; end
    n = 0;
    while (!ifa.lcd[0] && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (ifa.lcd[0] && n < 50) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk("addr_p3c40", ifa.ram_addr, 424);
    chk("mid_cs_low", ifa.lcd[0], 0);
    #2 rst_a = 1'b0;
    #1;
    chk("arst_lcd",   ifa.lcd, 4'b0011);
    chk("arst_addr",  ifa.ram_addr, 0);
    chk("arst_fbusy", ifa.frame_busy, 0);
    chk("arst_init",  ifa.init_done, 0);
    @(negedge clk);
    rst_a = 1'b1;
    run_init_a("reinit");

    // Small instance: bit timing on the first init byte.
    rst_b = 1'b1;
    n = 0;
    while (!u_dut_b.u_tx.o_busy && n < 100) begin @(negedge clk); n++; end
    n = 0; runs = 0; bad = 0; len = 0; prv = 1'b1;
    while (u_dut_b.u_tx.o_busy && n < 200) begin
      if (!ifb.lcd[0]) begin
        if (len != 0 && ifb.lcd[1] != prv) begin
          runs++; if (len != 4) bad++; len = 0;
        end
        prv = ifb.lcd[1]; len++;
      end
      n++; @(negedge clk);
    end
    if (len != 0) begin runs++; if (len != 4) bad++; end
    chk("busy_width", n, 72);
    chk("scl_runs", runs, 17);
    chk("scl_half_bad", bad, 0);
    chk("b_byte0", qb[0], {1'b0, 8'hE2});
    n = 0;
    while (!ifb.init_done && n < 3000) begin @(negedge clk); n++; end
    chk("b_init_done", ifb.init_done, 1);

    // Three extra requests during a frame coalesce into one more frame.
    base = qb.size(); d0 = ndone[1];
    pulse_req_b();
    repeat (50) @(negedge clk);  pulse_req_b();
    repeat (100) @(negedge clk); pulse_req_b();
    repeat (100) @(negedge clk); pulse_req_b();
    n = 0;
    while (ndone[1] < d0 + 2 && n < 5000) begin @(negedge clk); n++; end
    repeat (1500) @(negedge clk);
    chk("coalesce_frames", ndone[1] - d0, 2);
    chk("b_nbytes", qb.size() - base, 28);
    chk("b_idle_fbusy", ifb.frame_busy, 0);
    errs = 0;
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 2; p++) begin
        if (qb[base+f*14+p*7]   !== {1'b0, 8'hB0 + 8'(p)}) errs++;
        if (qb[base+f*14+p*7+1] !== {1'b0, 8'h10}) errs++;
        if (qb[base+f*14+p*7+2] !== {1'b0, 8'h00}) errs++;
        for (int k = 0; k < 4; k++)
          if (qb[base+f*14+p*7+3+k] !== {1'b1, 8'(p*4+k)}) errs++;
      end
    chk("b_frame_errs", errs, 0);

    // Request landing in the frame_done cycle: one IDLE cycle, then the next frame.
    d0 = ndone[1];
    pulse_req_b();
    n = 0;
    while (!ifb.frame_done && n < 3000) begin @(negedge clk); n++; end
    ifb.frame_req = 1'b1; @(negedge clk); ifb.frame_req = 1'b0;
    gap = 0;
    while (!ifb.frame_busy && gap < 20) begin gap++; @(negedge clk); end
    chk("done_req_gap", gap, 1);
    n = 0;
    while (ndone[1] < d0 + 2 && n < 5000) begin @(negedge clk); n++; end
    repeat (1500) @(negedge clk);
    chk("done_req_frames", ndone[1] - d0, 2);

    // auto_refresh: back-to-back frames; dropping it mid-frame finishes that frame only.
    d0 = ndone[1];
    ifb.auto_refresh = 1'b1;
    n = 0;
    while (ndone[1] < d0 + 2 && n < 5000) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    chk("auto_busy", ifb.frame_busy, 1);
    ifb.auto_refresh = 1'b0;
    repeat (2500) @(negedge clk);
    chk("auto_frames", ndone[1] - d0, 3);
    chk("si_stable_bad", si_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
